// File: rtl/taxi_eth_addr_swap.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | taxi_eth_addr_swap: AXI4-Stream stage swapping Ethernet dst/src MAC addresses. |
// | Revision: 1.0                                                                  |
// +--------------------------------------------------------------------------------+
module taxi_eth_addr_swap #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [7:0]        s_axis_tid,
  input  logic              s_axis_tuser,

  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [7:0]        m_axis_tid,
  output logic              m_axis_tuser,

  input  logic              enable,
  output logic              stat_swapped,
  output logic              stat_bypass
);

  generate
    if (DATA_W != 64 || KEEP_W != DATA_W/8) begin : g_width_check
      $error("taxi_eth_addr_swap: only DATA_W=64 with KEEP_W=8 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_BODY  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t              state_q;
  logic                swap_f_q;

  logic [DATA_W-1:0]   h_data_q;
  logic [KEEP_W-1:0]   h_keep_q;
  logic                h_last_q;
  logic [7:0]          h_id_q;
  logic                h_user_q;

  logic                r_valid_q;
  logic [DATA_W-1:0]   r_data_q;
  logic [KEEP_W-1:0]   r_keep_q;
  logic                r_last_q;
  logic [7:0]          r_id_q;
  logic                r_user_q;
  logic                r_swap_q;
  logic                r_byp_q;

  logic                w_r_free;
  logic                w_accept;
  logic                w_swap;
  logic [DATA_W-1:0]   w_swap_w0;
  logic [DATA_W-1:0]   w_swap_w1;

  assign w_r_free      = !r_valid_q || m_axis_tready;
  assign s_axis_tready = !rst && w_r_free && (state_q != ST_FLUSH);
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  // A frame ending on word 1 must carry at least bytes 8-11 to hold a full source address.
  assign w_swap    = swap_f_q && (!s_axis_tlast || (&s_axis_tkeep[3:0]));
  assign w_swap_w0 = {h_data_q[15:0], s_axis_tdata[31:0], h_data_q[63:48]};
  assign w_swap_w1 = {s_axis_tdata[63:32], h_data_q[47:16]};

  assign m_axis_tvalid = r_valid_q;
  assign m_axis_tdata  = r_data_q;
  assign m_axis_tkeep  = r_keep_q;
  assign m_axis_tlast  = r_last_q;
  assign m_axis_tid    = r_id_q;
  assign m_axis_tuser  = r_user_q;

  assign stat_swapped = r_valid_q && m_axis_tready && r_swap_q;
  assign stat_bypass  = r_valid_q && m_axis_tready && r_byp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      swap_f_q  <= 1'b0;
      h_data_q  <= '0;
      h_keep_q  <= '0;
      h_last_q  <= 1'b0;
      h_id_q    <= '0;
      h_user_q  <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_keep_q  <= '0;
      r_last_q  <= 1'b0;
      r_id_q    <= '0;
      r_user_q  <= 1'b0;
      r_swap_q  <= 1'b0;
      r_byp_q   <= 1'b0;
    end else begin
      if (m_axis_tready) begin
        r_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            if (s_axis_tlast) begin
              r_valid_q <= 1'b1;
              r_data_q  <= s_axis_tdata;
              r_keep_q  <= s_axis_tkeep;
              r_last_q  <= 1'b1;
              r_id_q    <= s_axis_tid;
              r_user_q  <= s_axis_tuser;
              r_swap_q  <= 1'b0;
              r_byp_q   <= 1'b1;
            end else begin
              h_data_q <= s_axis_tdata;
              h_keep_q <= s_axis_tkeep;
              h_last_q <= 1'b0;
              h_id_q   <= s_axis_tid;
              h_user_q <= s_axis_tuser;
              swap_f_q <= enable;
              state_q  <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (w_accept) begin
            r_valid_q <= 1'b1;
            r_data_q  <= w_swap ? w_swap_w0 : h_data_q;
            r_keep_q  <= h_keep_q;
            r_last_q  <= h_last_q;
            r_id_q    <= h_id_q;
            r_user_q  <= h_user_q;
            r_swap_q  <= w_swap;
            r_byp_q   <= !w_swap;
            h_data_q  <= w_swap ? w_swap_w1 : s_axis_tdata;
            h_keep_q  <= s_axis_tkeep;
            h_last_q  <= s_axis_tlast;
            h_id_q    <= s_axis_tid;
            h_user_q  <= s_axis_tuser;
            state_q   <= s_axis_tlast ? ST_FLUSH : ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_accept) begin
            r_valid_q <= 1'b1;
            r_data_q  <= h_data_q;
            r_keep_q  <= h_keep_q;
            r_last_q  <= h_last_q;
            r_id_q    <= h_id_q;
            r_user_q  <= h_user_q;
            r_swap_q  <= 1'b0;
            r_byp_q   <= 1'b0;
            h_data_q  <= s_axis_tdata;
            h_keep_q  <= s_axis_tkeep;
            h_last_q  <= s_axis_tlast;
            h_id_q    <= s_axis_tid;
            h_user_q  <= s_axis_tuser;
            if (s_axis_tlast) begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (w_r_free) begin
            r_valid_q <= 1'b1;
            r_data_q  <= h_data_q;
            r_keep_q  <= h_keep_q;
            r_last_q  <= h_last_q;
            r_id_q    <= h_id_q;
            r_user_q  <= h_user_q;
            r_swap_q  <= 1'b0;
            r_byp_q   <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_taxi_eth_addr_swap.sv
`default_nettype none
// Testbench for taxi_eth_addr_swap: random frames checked against a byte-level address-swap model.
module tb_taxi_eth_addr_swap;

  logic        clk;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  s_tid;
  logic        s_tuser;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [7:0]  m_tid;
  logic        m_tuser;
  logic        enable;
  logic        stat_sw;
  logic        stat_byp;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic        user;
    logic        sw;
    logic        byp;
  } beat_t;

  beat_t       exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          rdy_pct = 100;
  bit          mon_en = 0;
  int          cnt_sw = 0, cnt_byp = 0, cnt_beats = 0;
  int          exp_sw = 0, exp_byp = 0;
  int          last_xfer_edge = 0, first_xfer_edge = 0;
  logic [63:0] first_word = '0;
  logic [7:0]  last_keep = '0;

  taxi_eth_addr_swap #(.DATA_W(64), .KEEP_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tid    (s_tid),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .m_axis_tuser  (m_tuser),
    .enable        (enable),
    .stat_swapped  (stat_sw),
    .stat_bypass   (stat_byp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = ($urandom_range(0, 99) < rdy_pct);
  end

  // Output scoreboard: every transfer is matched against the next modelled beat.
  initial begin : monitor
    beat_t       e;
    logic [63:0] mask;
    logic [63:0] pdata;
    bit          pstall;
    pstall = 0;
    pdata  = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pstall = 0;
      end else begin
        if (pstall) begin
          tests_run++;
          if (m_tvalid !== 1'b1 || m_tdata !== pdata) begin
            tests_failed++;
            $display("FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=%h", m_tvalid, m_tdata, pdata);
          end
        end
        if (m_tvalid && m_tready) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL extra_beat: got data=%h, expected no beat", m_tdata);
          end else begin
            e = exp_q.pop_front();
            for (int l = 0; l < 8; l++) mask[8*l +: 8] = {8{e.keep[l]}};
            if ((m_tdata & mask) !== (e.data & mask) || m_tkeep !== e.keep || m_tlast !== e.last ||
                m_tid !== e.id || m_tuser !== e.user) begin
              tests_failed++;
              $display("FAIL beat: got data=%h keep=%h last=%b id=%h user=%b, expected data=%h keep=%h last=%b id=%h user=%b",
                       m_tdata & mask, m_tkeep, m_tlast, m_tid, m_tuser, e.data & mask, e.keep, e.last, e.id, e.user);
            end
            tests_run++;
            if (stat_sw !== e.sw || stat_byp !== e.byp) begin
              tests_failed++;
              $display("FAIL stat_beat: got swapped=%b bypass=%b, expected swapped=%b bypass=%b", stat_sw, stat_byp, e.sw, e.byp);
            end
            if (e.sw || e.byp) begin
              first_word      = m_tdata;
              first_xfer_edge = cyc + 1;
            end
            if (m_tlast) last_keep = m_tkeep;
            cnt_beats++;
            last_xfer_edge = cyc + 1;
          end
        end else begin
          tests_run++;
          if (stat_sw !== 1'b0 || stat_byp !== 1'b0) begin
            tests_failed++;
            $display("FAIL stat_idle: got swapped=%b bypass=%b, expected 0 0", stat_sw, stat_byp);
          end
        end
        if (stat_sw === 1'b1) cnt_sw++;
        if (stat_byp === 1'b1) cnt_byp++;
        pstall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
        pdata  = m_tdata;
      end
    end
  end

  // Builds one frame, queues the expected output, then drives it with optional valid gaps.
  task automatic send_frame(input int len, input bit en, input bit fixed_hdr, input int vpct,
                            input bit scramble, input int abort_beats, output int acc0);
    logic [7:0]  ib[];
    logic [7:0]  ob[];
    logic [63:0] din;
    logic [63:0] dout;
    logic [7:0]  keep;
    logic [7:0]  id;
    logic        user;
    beat_t       e;
    int          nb, n, waits;
    bit          swp, acc;
    acc0 = 0;
    ib = new[len];
    for (int i = 0; i < len; i++) ib[i] = 8'($urandom_range(0, 255));
    if (fixed_hdr) begin
      for (int i = 0; i < 12; i++) ib[i] = 8'h00;
      ib[0] = 8'h02; ib[5] = 8'h01; ib[6] = 8'h02; ib[11] = 8'h02;
    end
    swp = en && (len >= 12);
    ob = new[len](ib);
    if (swp) begin
      for (int i = 0; i < 6; i++) begin
        ob[i]     = ib[i + 6];
        ob[i + 6] = ib[i];
      end
    end
    nb = (len + 7) / 8;
    enable = en;
    for (int b = 0; b < nb; b++) begin
      n = len - 8 * b;
      if (n > 8) n = 8;
      keep = 8'((16'd1 << n) - 16'd1);
      id   = 8'($urandom_range(0, 255));
      user = 1'($urandom_range(0, 1));
      for (int l = 0; l < 8; l++) begin
        din[8*l +: 8]  = (l < n) ? ib[8*b + l] : 8'h00;
        dout[8*l +: 8] = (l < n) ? ob[8*b + l] : 8'h00;
      end
      if (abort_beats == 0) begin
        e.data = dout; e.keep = keep; e.last = (b == nb - 1); e.id = id; e.user = user;
        e.sw   = (b == 0) && swp;
        e.byp  = (b == 0) && !swp;
        exp_q.push_back(e);
      end
      if (vpct < 100) begin
        while ($urandom_range(0, 99) >= vpct) begin
          s_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      s_tdata = din; s_tkeep = keep; s_tlast = (b == nb - 1); s_tid = id; s_tuser = user;
      s_tvalid = 1'b1;
      acc   = 0;
      waits = 0;
      while (!acc) begin
        @(negedge clk);
        acc = (s_tready === 1'b1);
        if (acc && b == 0) acc0 = cyc + 1;
        @(posedge clk);
        #1;
        waits++;
        if (!acc && waits > 2000) begin
          tests_run++;
          tests_failed++;
          $display("FAIL accept_timeout: got tready=0 for %0d cycles, expected tready=1", waits);
          s_tvalid = 1'b0;
          return;
        end
      end
      if (b == 0 && scramble) enable = 1'($urandom_range(0, 1));
      if (abort_beats != 0 && b + 1 == abort_beats) return;
    end
    s_tvalid = 1'b0;
    if (abort_beats == 0) begin
      if (swp) exp_sw++;
      else exp_byp++;
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && m_tvalid === 1'b0) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || stat_sw !== 1'b0 || stat_byp !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got m_tvalid=%b s_tready=%b sw=%b byp=%b, expected 0 0 0 0", m_tvalid, s_tready, stat_sw, stat_byp);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got s_tready=%b m_tvalid=%b, expected 1 0", s_tready, m_tvalid);
    end
    @(posedge clk);
    #1;
    mon_en = 1;
  endtask

  task automatic test_swap_60(input bit en, input logic [63:0] want_w0);
    int a0, sw0, byp0;
    bit ok;
    sw0 = cnt_sw; byp0 = cnt_byp;
    send_frame(60, en, 1, 100, 0, 0, a0);
    wait_drain(200, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL drain_60: got %0d beats pending, expected 0", exp_q.size()); end
    tests_run++;
    if (first_word !== want_w0) begin
      tests_failed++;
      $display("FAIL addr_word0: got %h, expected %h", first_word, want_w0);
    end
    tests_run++;
    if (last_keep !== 8'h0F) begin tests_failed++; $display("FAIL last_keep_60: got %h, expected 0f", last_keep); end
    tests_run++;
    if (first_xfer_edge - a0 !== 2) begin
      tests_failed++;
      $display("FAIL latency_multi: got %0d, expected 2", first_xfer_edge - a0);
    end
    tests_run++;
    if (cnt_sw - sw0 !== (en ? 1 : 0) || cnt_byp - byp0 !== (en ? 0 : 1)) begin
      tests_failed++;
      $display("FAIL stat_60: got swapped=%0d bypass=%0d, expected en=%b pulse", cnt_sw - sw0, cnt_byp - byp0, en);
    end
  endtask

  task automatic test_short_frames();
    int a0, sw0, byp0;
    bit ok;
    sw0 = cnt_sw; byp0 = cnt_byp;
    send_frame(8, 1, 0, 100, 0, 0, a0);
    wait_drain(50, ok);
    tests_run++;
    if (!ok || first_xfer_edge - a0 !== 1) begin
      tests_failed++;
      $display("FAIL latency_single: got %0d, expected 1", first_xfer_edge - a0);
    end
    send_frame(11, 1, 0, 100, 0, 0, a0);
    wait_drain(50, ok);
    tests_run++;
    if (!ok || cnt_byp - byp0 !== 2 || cnt_sw - sw0 !== 0) begin
      tests_failed++;
      $display("FAIL stat_short: got bypass=%0d swapped=%0d, expected 2 0", cnt_byp - byp0, cnt_sw - sw0);
    end
    send_frame(12, 1, 1, 100, 0, 0, a0);
    wait_drain(50, ok);
    tests_run++;
    if (!ok || cnt_sw - sw0 !== 1 || first_word !== 64'h0002020000000002) begin
      tests_failed++;
      $display("FAIL swap_12: got swapped=%0d word0=%h, expected 1 0002020000000002", cnt_sw - sw0, first_word);
    end
  endtask

  task automatic test_back_to_back();
    int a0, t0, sw0, beats0;
    bit ok;
    rdy_pct = 100;
    @(posedge clk);
    #1;
    sw0 = cnt_sw; beats0 = cnt_beats; t0 = 0;
    for (int f = 0; f < 100; f++) begin
      send_frame(64, 1, 0, 100, 0, 0, a0);
      if (f == 0) t0 = a0;
    end
    wait_drain(100, ok);
    tests_run++;
    if (!ok || cnt_beats - beats0 !== 800 || cnt_sw - sw0 !== 100) begin
      tests_failed++;
      $display("FAIL b2b_beats: got beats=%0d swapped=%0d, expected 800 100", cnt_beats - beats0, cnt_sw - sw0);
    end
    // 9 cycles per frame (8 beats + FLUSH bubble): last input beat at 100*9-2, emitted 2 later.
    tests_run++;
    if (last_xfer_edge - t0 !== 100 * 9) begin
      tests_failed++;
      $display("FAIL b2b_cycles: got %0d, expected %0d", last_xfer_edge - t0, 100 * 9);
    end
  endtask

  task automatic test_random();
    int a0, len;
    bit ok;
    rdy_pct = 50;
    for (int f = 0; f < 1000; f++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(1, 1518);
      else len = $urandom_range(1, 64);
      send_frame(len, 1'($urandom_range(0, 1)), 0, 70, 1, 0, a0);
    end
    wait_drain(20000, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL drain_random: got %0d beats pending, expected 0", exp_q.size()); end
    tests_run++;
    if (cnt_sw !== exp_sw || cnt_byp !== exp_byp) begin
      tests_failed++;
      $display("FAIL stat_totals: got swapped=%0d bypass=%0d, expected %0d %0d", cnt_sw, cnt_byp, exp_sw, exp_byp);
    end
  endtask

  task automatic test_reset_midframe();
    int a0, sw0, byp0;
    bit ok;
    rdy_pct = 100;
    @(posedge clk);
    #1;
    mon_en = 0;
    send_frame(1500, 1, 0, 100, 0, 20, a0);
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (m_tvalid !== 1'b0 || stat_sw !== 1'b0 || stat_byp !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_abort: cycle %0d got m_tvalid=%b sw=%b byp=%b, expected 0 0 0", i, m_tvalid, stat_sw, stat_byp);
      end
    end
    @(posedge clk);
    #1;
    mon_en = 1;
    sw0 = cnt_sw; byp0 = cnt_byp;
    send_frame(64, 1, 1, 100, 0, 0, a0);
    send_frame(11, 1, 0, 100, 0, 0, a0);
    wait_drain(100, ok);
    tests_run++;
    if (!ok || cnt_sw - sw0 !== 1 || cnt_byp - byp0 !== 1 || first_word !== 64'h0000000000000000 + first_word) begin
      tests_failed++;
      $display("FAIL post_reset: got swapped=%0d bypass=%0d pending=%0d, expected 1 1 0", cnt_sw - sw0, cnt_byp - byp0, exp_q.size());
    end
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tid    = '0;
    s_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_swap_60(1'b1, 64'h0002020000000002);
    test_swap_60(1'b0, 64'h0002010000000002);
    test_short_frames();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
